// File: rtl/perf_event_counter.sv
// Performance counters: run cycles plus NUM_EVENTS event lines over a start/stop window, read via shadow regs.
// Latency: counters update on the edge that samples an event; rd_data/rd_valid appear one edge after rd_en.
// Backpressure: none; every rd_en yields one rd_valid pulse, back-to-back reads give one result per cycle.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   start/stop/clear/snap   window control pulses (priority clear > stop > start > snap)
//   event_in                per-channel event strobes, counted on every RUN cycle they are high
//   rd_en, rd_sel           read request; sel 0 = cycle counter, k = event channel k-1
//   rd_data, rd_valid       registered shadow value and its one-cycle valid strobe
//   overflow                sticky per-counter overflow flags (bit 0 = cycles)
//   running                 high while the measurement window is open
module perf_event_counter #(
    parameter int NUM_EVENTS = 4,
    parameter int CNT_WIDTH  = 64,
    parameter bit SATURATE   = 1'b1,
    parameter int SEL_W      = $clog2(NUM_EVENTS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  snap,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  rd_en,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic                  rd_valid,
    output logic [NUM_EVENTS:0]   overflow,
    output logic                  running
);

    localparam int NCH = NUM_EVENTS + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] cnt      [NCH];
    logic [CNT_WIDTH-1:0] cnt_nxt  [NCH];
    logic [CNT_WIDTH-1:0] shadow   [NCH];
    logic [NCH-1:0]       inc;
    logic [NCH-1:0]       ovf_hit;
    logic [CNT_WIDTH-1:0] rd_mux;

    // Window control. stop is only honoured in RUN, so a same-cycle start+stop
    // in RUN lands in FROZEN; start while already in RUN just keeps counting.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = RUN;
                RUN:     if (stop)  state_nxt = FROZEN;
                FROZEN:  if (start) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Counting is gated on the current state, so the cycle that sampled start
    // (still IDLE/FROZEN) adds nothing, while the stop cycle (still RUN) counts.
    always_comb begin
        inc     = '0;
        ovf_hit = '0;
        if (state == RUN) begin
            inc = {event_in, 1'b1};
        end
        for (int i = 0; i < NCH; i++) begin
            ovf_hit[i] = inc[i] & (&cnt[i]);
            cnt_nxt[i] = cnt[i];
            if (inc[i]) begin
                // All-ones + 1 naturally wraps to zero; saturation just holds.
                if (ovf_hit[i] && SATURATE) begin
                    cnt_nxt[i] = cnt[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Out-of-range selects match no channel and read back as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_mux = shadow[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            running  <= 1'b0;
            overflow <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i]    <= '0;
                shadow[i] <= '0;
            end
        end else begin
            state   <= state_nxt;
            running <= (state_nxt == RUN);

            // Read samples the pre-update shadow, so a same-cycle snap/stop/clear
            // becomes visible only to the following read.
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end

            if (clear) begin
                overflow <= '0;
                for (int i = 0; i < NCH; i++) begin
                    cnt[i]    <= '0;
                    shadow[i] <= '0;
                end
            end else begin
                overflow <= overflow | ovf_hit;
                for (int i = 0; i < NCH; i++) begin
                    cnt[i] <= cnt_nxt[i];
                    // Shadows take the value including this cycle's increment.
                    if ((state == RUN) && (stop || snap)) begin
                        shadow[i] <= cnt_nxt[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_perf_event_counter.sv
// Testbench for perf_event_counter: two 8-bit instances (saturating and wrapping)
// share one stimulus stream; a cycle-level behavioural model predicts every output.
// Directed scenarios from the test plan are followed by a randomized phase.
module tb_perf_event_counter;

    logic       clk = 1'b0;
    logic       reset, start, stop, clear, snap, rd_en;
    logic [3:0] event_in;
    logic [2:0] rd_sel;

    logic [7:0] rd_data0, rd_data1;
    logic       rd_valid0, rd_valid1;
    logic [4:0] ovf0, ovf1;
    logic       running0, running1;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model: counts as plain integers, state as 0=idle 1=run 2=frozen.
    int       m_state;
    int       m_cnt [2][5];
    int       m_sh  [2][5];
    bit [4:0] m_ovf [2];
    int       m_rd  [2];
    bit       m_rv;

    always #5 clk = ~clk;

    perf_event_counter #(.NUM_EVENTS(4), .CNT_WIDTH(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .snap(snap),
        .event_in(event_in), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .overflow(ovf0), .running(running0)
    );

    perf_event_counter #(.NUM_EVENTS(4), .CNT_WIDTH(8), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .snap(snap),
        .event_in(event_in), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .overflow(ovf1), .running(running1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_zero();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 5; k++) begin
                m_cnt[d][k] = 0;
                m_sh[d][k]  = 0;
            end
            m_ovf[d] = '0;
        end
        m_state = 0;
    endtask

    task automatic model_update();
        if (reset) begin
            model_zero();
            m_rd[0] = 0;
            m_rd[1] = 0;
            m_rv    = 1'b0;
        end else begin
            m_rv = rd_en;
            for (int d = 0; d < 2; d++) begin
                if (rd_en) m_rd[d] = (rd_sel <= 3'd4) ? m_sh[d][rd_sel] : 0;
            end
            if (clear) begin
                model_zero();
            end else if (m_state == 1) begin
                for (int d = 0; d < 2; d++) begin
                    for (int k = 0; k < 5; k++) begin
                        if (k == 0 || event_in[k-1]) begin
                            if (m_cnt[d][k] + 1 > 255) begin
                                m_ovf[d][k] = 1'b1;
                                m_cnt[d][k] = (d == 0) ? 255 : (m_cnt[d][k] + 1) % 256;
                            end else begin
                                m_cnt[d][k] = m_cnt[d][k] + 1;
                            end
                        end
                        if (stop || snap) m_sh[d][k] = m_cnt[d][k];
                    end
                end
                if (stop) m_state = 2;
            end else if (start) begin
                m_state = 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("running0",  running0,  m_state == 1);
        chk("running1",  running1,  m_state == 1);
        chk("rd_valid0", rd_valid0, m_rv);
        chk("rd_valid1", rd_valid1, m_rv);
        chk("rd_data0",  rd_data0,  m_rd[0]);
        chk("rd_data1",  rd_data1,  m_rd[1]);
        chk("overflow0", ovf0,      m_ovf[0]);
        chk("overflow1", ovf1,      m_ovf[1]);
    endtask

    // One clock: inputs are stable across the edge, outputs checked 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask

    task automatic quiet();
        reset = 0; start = 0; stop = 0; clear = 0; snap = 0;
        rd_en = 0; rd_sel = 0; event_in = 0;
    endtask

    task automatic pulse_clear();
        clear = 1; step(); clear = 0;
    endtask

    task automatic pulse_start();
        start = 1; step(); start = 0;
    endtask

    task automatic read_sel(input int s);
        rd_en = 1; rd_sel = s[2:0]; step(); rd_en = 0;
    endtask

    // n RUN cycles with a fixed event pattern; stop is raised on the last one.
    task automatic run_then_stop(input int n, input logic [3:0] ev);
        event_in = ev;
        for (int c = 1; c <= n; c++) begin
            stop = (c == n);
            step();
        end
        stop = 0; event_in = 0;
    endtask

    initial begin
        quiet();
        reset = 1;
        step();
        step();
        reset = 0;
        chk("reset_running", running0, 1'b0);
        chk("reset_ovf", ovf0, 5'd0);

        // 1: ten RUN cycles, event 0 on three of them.
        pulse_start();
        for (int c = 1; c <= 10; c++) begin
            event_in = {3'b000, (c == 1 || c == 4 || c == 7)};
            stop = (c == 10);
            step();
        end
        stop = 0; event_in = 0;
        read_sel(0);
        chk("t1_cycles", rd_data0, 8'd10);
        chk("t1_valid", rd_valid0, 1'b1);
        read_sel(1);
        chk("t1_ev0", rd_data1, 8'd3);
        chk("t1_running", running0, 1'b0);
        step();
        chk("t1_valid_drop", rd_valid0, 1'b0);

        // 2: frozen cycles between windows are not counted.
        pulse_clear();
        pulse_start();
        run_then_stop(5, 4'h0);
        for (int c = 0; c < 7; c++) step();
        pulse_start();
        run_then_stop(4, 4'h0);
        read_sel(0);
        chk("t2_cycles", rd_data0, 8'd9);

        // 3: 300 cycles with event 1 high -> saturate vs wrap.
        pulse_clear();
        pulse_start();
        run_then_stop(300, 4'b0010);
        read_sel(2);
        chk("t3_sat", rd_data0, 8'd255);
        chk("t3_wrap", rd_data1, 8'd44);
        chk("t3_ovf_sat", ovf0[2], 1'b1);
        chk("t3_ovf_wrap", ovf1[2], 1'b1);
        chk("t3_ovf_idle_ch", ovf0[1], 1'b0);

        // 4: snap at cycle 6, read mid-window, stop at 12.
        pulse_clear();
        pulse_start();
        for (int c = 1; c <= 12; c++) begin
            snap = (c == 6);
            rd_en = (c == 10);
            rd_sel = 0;
            stop = (c == 12);
            step();
            if (c == 10) chk("t4_snap", rd_data0, 8'd6);
        end
        snap = 0; stop = 0; rd_en = 0;
        read_sel(0);
        chk("t4_stop", rd_data0, 8'd12);

        // 5: start+stop together in RUN -> frozen; clear with events active.
        pulse_clear();
        pulse_start();
        run_then_stop(1, 4'hF);
        pulse_start();
        for (int c = 0; c < 3; c++) step();
        start = 1; stop = 1; step(); start = 0; stop = 0;
        chk("t5_frozen", running0, 1'b0);
        event_in = 4'hF;
        pulse_clear();
        event_in = 0;
        chk("t5_ovf", ovf0, 5'd0);
        chk("t5_idle", running1, 1'b0);
        for (int s = 0; s < 5; s++) begin
            read_sel(s);
            chk("t5_zero", rd_data0, 8'd0);
        end

        // 6: out-of-range select, then reset mid-window.
        pulse_start();
        run_then_stop(4, 4'hF);
        read_sel(4);
        chk("t6_ch3", rd_data0, 8'd4);
        read_sel(5);
        chk("t6_oor", rd_data0, 8'd0);
        chk("t6_oor_valid", rd_valid0, 1'b1);
        read_sel(7);
        chk("t6_oor7", rd_data1, 8'd0);
        pulse_start();
        for (int c = 0; c < 3; c++) step();
        reset = 1; step(); reset = 0;
        chk("t6_rst_running", running0, 1'b0);
        for (int s = 0; s < 5; s++) begin
            read_sel(s);
            chk("t6_rst_zero", rd_data0, 8'd0);
        end

        // Randomized phase: short windows first, then long ones to reach overflow.
        for (int i = 0; i < 4000; i++) begin
            int stop_div;
            stop_div = (i < 2000) ? 25 : 400;
            reset    = ($urandom_range(0, 499) == 0);
            clear    = ($urandom_range(0, stop_div * 3) == 0);
            stop     = ($urandom_range(0, stop_div - 1) == 0);
            start    = ($urandom_range(0, 9) == 0);
            snap     = ($urandom_range(0, 14) == 0);
            rd_en    = ($urandom_range(0, 1) == 1);
            rd_sel   = 3'($urandom_range(0, 7));
            event_in = 4'($urandom);
            step();
        end
        quiet();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
